ppm_sof_gen: RTL and testbench
==============================

# ppm_sof_gen

Parametrised start-of-frame generator for the PPM transmitter: on a one-cycle start request it serialises a configurable slot pattern onto `sof`, repeats it a run-time-selected number of times, and reports completion with a one-cycle `sof_done`. It sits between the transmitter control FSM (which issues `control_sof`) and the PPM slot modulator/output driver. It generalises the fixed SOF generator with a programmable pattern, slot width, repeat count, abort, busy flag and optional guard interval.

## Interface
Parameters:
- `SLOT_CYCLES`, 4: clock cycles per PPM slot; must be at least 1.
- `PATTERN_LEN`, 8: slots per SOF pattern; must be at least 2.
- `PATTERN`, 8'hE4: SOF pattern, `PATTERN_LEN` bits, sent MSB first.
- `GUARD_SLOTS`, 4: length of the low guard interval in slots; used only with `SOF_GUARD_EN`.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: synchronous, active-low reset.
- `control_sof`, input, 1: start request; sampled only in IDLE.
- `rep`, input, 4: extra pattern repeats, giving `rep`+1 patterns in total; latched at start.
- `abort`, input, 1: synchronous cancel.
- `sof`, output, 1: registered serial SOF output.
- `sof_busy`, output, 1: high while a SOF sequence is in progress.
- `sof_done`, output, 1: one-cycle completion pulse.
- `slot_idx`, output, clog2(`PATTERN_LEN`): index of the slot currently being sent; 0 when idle.

## Operation
- All outputs are registered. Reset value is 0 for `sof`, `sof_busy`, `sof_done` and `slot_idx`. The FSM resets to IDLE.
- FSM states: IDLE, SEND, GUARD (present only with the macro).
- IDLE -> SEND: taken on an edge where `control_sof`=1 and `abort`=0.
  - `rep` is latched.
  - Slot, cycle and repeat counters are cleared.
  - `sof` takes `PATTERN[PATTERN_LEN-1]` and `sof_busy` goes to 1.
- In SEND:
  - The cycle counter counts 0 to `SLOT_CYCLES`-1.
  - At wrap, the slot counter advances and `sof` loads the next bit (MSB to LSB).
  - At the last slot wrap, the repeat counter increments and the slot counter wraps to 0 if repeats remain.
- End of the last slot of the last repeat:
  - Without the macro: go to IDLE. `sof`=0, `sof_busy`=0, `sof_done`=1 for one cycle.
  - With the macro: go to GUARD. `sof`=0, `sof_busy` stays 1.
- GUARD: lasts `GUARD_SLOTS`×`SLOT_CYCLES` cycles, then goes to IDLE with the `sof_done` pulse.
- `control_sof` outside IDLE is ignored, not queued. A request in the same cycle as `sof_done` is also ignored.
- `abort`=1 in any state: the next edge goes to IDLE and clears all outputs. No `sof_done` pulse is produced. Abort has priority over `control_sof`.
- Reset during SEND or GUARD behaves like abort and also clears the latched `rep`.
- Counter widths are clog2 of their terminal value, with a minimum of 1 bit. `SLOT_CYCLES`=1 gives one clock per slot.

## Timing
- Start is sampled at edge E0. `sof` is valid from E0 for `PATTERN_LEN`×`SLOT_CYCLES`×(`rep`+1) cycles.
- Without the macro: `sof_done` is high in the cycle after edge E0 + `PATTERN_LEN`×`SLOT_CYCLES`×(`rep`+1). It falls one cycle later.
- With the macro: add `GUARD_SLOTS`×`SLOT_CYCLES` cycles to the done timing.
- The earliest accepted restart is the edge after the `sof_done` cycle. The dead time between sequences is therefore at least 1 cycle.
- `slot_idx` updates on the same edge as `sof`.

## Configuration
- `SOF_GUARD_EN` defined: the GUARD state exists, and `sof_done` is delayed by the guard interval while `sof_busy` stays high.
- `SOF_GUARD_EN` undefined: there is no GUARD state, `GUARD_SLOTS` is ignored, and `done` follows the last slot directly.

## Test plan
All scenarios use the defaults (`SLOT_CYCLES`=4, `PATTERN_LEN`=8, `PATTERN`=8'hE4) unless stated.
1. Hold `rst_n`=0 for 2 cycles, then release with no request -> `sof`, `sof_busy`, `sof_done` and `slot_idx` all stay 0.
2. Pulse `control_sof` for 1 cycle with `rep`=0 -> `sof` sequence 1,1,1,0,0,1,0,0 with 4 cycles per bit; `sof_busy` high for 32 cycles; single `sof_done` at cycle 32 after E0.
3. Set `rep`=2 and start -> pattern appears 3 times back to back (96 cycles); exactly one `sof_done`, at cycle 96; a `rep` change mid-sequence has no effect.
4. Pulse `control_sof` again at cycle 10 of a sequence, and also in the `sof_done` cycle -> both are ignored; a new start the cycle after `done` is accepted.
5. Assert `abort` at cycle 10 -> `sof` and `sof_busy` are 0 at the next edge, with no `done`. Repeat the scenario with `rst_n`=0 at cycle 10 and expect the same result. A fresh start then gives the full scenario 2 waveform.
6. Build with `SOF_GUARD_EN` and `GUARD_SLOTS`=4, `rep`=0 -> `sof` is 0 from cycle 32; `sof_busy` stays high until `sof_done` at cycle 48.

Source files
------------

// File: rtl/ppm_sof_gen.sv
// Start-of-frame generator: serialises PATTERN onto sof, rep+1 times, then pulses sof_done.
// Optional low guard interval before sof_done when SOF_GUARD_EN is defined.
module ppm_sof_gen #(
    parameter int unsigned              SLOT_CYCLES = 4,
    parameter int unsigned              PATTERN_LEN = 8,
    parameter logic [PATTERN_LEN-1:0]   PATTERN     = 8'hE4,
    parameter int unsigned              GUARD_SLOTS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           control_sof,
    input  logic [3:0]                     rep,
    input  logic                           abort,
    output logic                           sof,
    output logic                           sof_busy,
    output logic                           sof_done,
    output logic [$clog2(PATTERN_LEN)-1:0] slot_idx
);

    localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned SW = $clog2(PATTERN_LEN);
    localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(PATTERN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND
`ifdef SOF_GUARD_EN
        , GUARD
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [CW-1:0] cyc, cyc_nxt;
    logic [SW-1:0] slot_nxt;
    logic [3:0]  rep_cnt, rep_cnt_nxt;
    logic [3:0]  rep_lat, rep_lat_nxt;
    logic        sof_nxt, busy_nxt, done_nxt;
    logic        start, slot_wrap, seq_end;

`ifdef SOF_GUARD_EN
    localparam int unsigned GUARD_CYCLES = GUARD_SLOTS * SLOT_CYCLES;
    localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    logic [GW-1:0] guard_cnt, guard_nxt;
    logic          guard_end;
    assign guard_end = (state == GUARD) && (guard_cnt == GUARD_LAST);
`endif

    // A request during the sof_done cycle is dropped, not treated as a restart.
    assign start     = control_sof && !sof_done;
    assign slot_wrap = (state == SEND) && (cyc == CYC_LAST);
    assign seq_end   = slot_wrap && (slot_idx == SLOT_LAST) && (rep_cnt == rep_lat);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cyc      <= '0;
            slot_idx <= '0;
            rep_cnt  <= '0;
            rep_lat  <= '0;
            sof      <= 1'b0;
            sof_busy <= 1'b0;
            sof_done <= 1'b0;
`ifdef SOF_GUARD_EN
            guard_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            cyc      <= cyc_nxt;
            slot_idx <= slot_nxt;
            rep_cnt  <= rep_cnt_nxt;
            rep_lat  <= rep_lat_nxt;
            sof      <= sof_nxt;
            sof_busy <= busy_nxt;
            sof_done <= done_nxt;
`ifdef SOF_GUARD_EN
            guard_cnt <= guard_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nxt = SEND;
                SEND: begin
                    if (seq_end) begin
`ifdef SOF_GUARD_EN
                        state_nxt = GUARD;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
`ifdef SOF_GUARD_EN
                GUARD: if (guard_end) state_nxt = IDLE;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cyc_nxt     = cyc;
        slot_nxt    = slot_idx;
        rep_cnt_nxt = rep_cnt;
        rep_lat_nxt = rep_lat;
        sof_nxt     = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
`ifdef SOF_GUARD_EN
        guard_nxt   = guard_cnt;
`endif
        case (state)
            IDLE: begin
                slot_nxt = '0;
                if (start) begin
                    rep_lat_nxt = rep;
                    cyc_nxt     = '0;
                    rep_cnt_nxt = '0;
                    sof_nxt     = PATTERN[PATTERN_LEN-1];
                    busy_nxt    = 1'b1;
                end
            end
            SEND: begin
                busy_nxt = 1'b1;
                if (!slot_wrap) begin
                    cyc_nxt = cyc + CW'(1);
                    sof_nxt = sof;
                end else begin
                    cyc_nxt = '0;
                    if (slot_idx != SLOT_LAST) begin
                        slot_nxt = slot_idx + SW'(1);
                        sof_nxt  = PATTERN[SLOT_LAST - slot_idx - SW'(1)];
                    end else begin
                        slot_nxt    = '0;
                        rep_cnt_nxt = rep_cnt + 4'd1;
                        if (!seq_end) begin
                            sof_nxt = PATTERN[PATTERN_LEN-1];
                        end else begin
`ifdef SOF_GUARD_EN
                            guard_nxt = '0;
`else
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef SOF_GUARD_EN
            GUARD: begin
                busy_nxt  = !guard_end;
                done_nxt  = guard_end;
                guard_nxt = guard_cnt + GW'(1);
            end
`endif
            default: ;
        endcase
        if (abort) begin
            cyc_nxt  = '0;
            slot_nxt = '0;
            sof_nxt  = 1'b0;
            busy_nxt = 1'b0;
            done_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_ppm_sof_gen.sv
// Bench for ppm_sof_gen: directed scenarios with literal expectations, then random traffic
// checked every cycle against a timeline model (position k since the accepted start).
module tb_ppm_sof_gen;

    localparam int SC = 4;
    localparam int PL = 8;
    localparam int GS = 4;
`ifdef SOF_GUARD_EN
    localparam int G = GS * SC;
`else
    localparam int G = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       control_sof = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] rep = 4'd0;
    logic       sof, sof_busy, sof_done;
    logic [2:0] slot_idx;

    ppm_sof_gen #(
        .SLOT_CYCLES (SC),
        .PATTERN_LEN (PL),
        .PATTERN     (8'hE4),
        .GUARD_SLOTS (GS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .control_sof (control_sof),
        .rep         (rep),
        .abort       (abort),
        .sof         (sof),
        .sof_busy    (sof_busy),
        .sof_done    (sof_done),
        .slot_idx    (slot_idx)
    );

    always #5 clk = ~clk;

    logic [7:0] pat = 8'b1110_0100;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a sequence is a timeline of N = PL*SC*(rep+1) pattern cycles, G guard cycles,
    // then one done cycle; k counts edges since the accepted start.
    bit m_seen_rst = 0;
    bit m_active   = 0;
    bit m_done     = 0;
    int m_k        = 0;
    int m_n        = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_seen_rst = 1;
            m_active   = 0;
            m_done     = 0;
        end else if (abort) begin
            m_active = 0;
            m_done   = 0;
        end else if (m_active) begin
            m_k++;
            if (m_k == m_n + G) begin
                m_active = 0;
                m_done   = 1;
            end
        end else begin
            if (control_sof && !m_done) begin
                m_active = 1;
                m_k      = 0;
                m_n      = PL * SC * (int'(rep) + 1);
            end
            m_done = 0;
        end
    end

    task automatic check_model();
        logic e_sof, e_busy;
        int   e_slot;
        if (!m_seen_rst) return;
        e_sof  = 1'b0;
        e_busy = m_active;
        e_slot = 0;
        if (m_active && m_k < m_n) begin
            e_slot = (m_k / SC) % PL;
            e_sof  = pat[PL - 1 - e_slot];
        end
        chk("model_sof", 32'(sof), 32'(e_sof));
        chk("model_busy", 32'(sof_busy), 32'(e_busy));
        chk("model_done", 32'(sof_done), 32'(m_done));
        chk("model_slot", 32'(slot_idx), 32'(e_slot));
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic start_seq(input logic [3:0] r);
        rep = r;
        control_sof = 1'b1;
        tick();
        control_sof = 1'b0;
    endtask

    // Entered at k=0; returns in the sof_done cycle (or after the bound).
    task automatic watch(input int n, input int poke_at, output int done_at);
        done_at = -1;
        for (int k = 0; k < 400; k++) begin
            if (sof_done) begin
                done_at = k;
                break;
            end
            if (k < n) chk("pattern_bit", 32'(sof), 32'(pat[7 - (k / 4) % 8]));
            else       chk("guard_low", 32'(sof), 0);
            if (k == poke_at) begin
                control_sof = 1'b1;
                rep = ~rep;
            end
            tick();
            control_sof = 1'b0;
        end
        if (done_at < 0) chk("done_timeout", 32'(done_at), 32'(n + G));
    endtask

    int d;
    int ndone;

    initial begin
        // Reset held two cycles, then idle with no request.
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_sof", 32'(sof), 0);
            chk("idle_busy", 32'(sof_busy), 0);
            chk("idle_done", 32'(sof_done), 0);
            chk("idle_slot", 32'(slot_idx), 0);
        end

        // Single pattern.
        start_seq(4'd0);
        chk("first_bit", 32'(sof), 1);
        chk("busy_at_start", 32'(sof_busy), 1);
        watch(32, -1, d);
        chk("done_at_rep0", 32'(d), 32'(32 + G));
        chk("busy_in_done", 32'(sof_busy), 0);
        tick();
        chk("done_one_cycle", 32'(sof_done), 0);

        // Three patterns; rep flipped mid-sequence and an extra request both ignored.
        tick();
        start_seq(4'd2);
        watch(96, 40, d);
        chk("done_at_rep2", 32'(d), 32'(96 + G));
        tick();

        // Request mid-sequence and during the done cycle ignored; the next one accepted.
        tick();
        start_seq(4'd0);
        watch(32, 10, d);
        chk("done_after_poke", 32'(d), 32'(32 + G));
        rep = 4'd0;
        control_sof = 1'b1;
        tick();
        chk("done_cycle_req_ignored", 32'(sof_busy), 0);
        tick();
        control_sof = 1'b0;
        chk("restart_accepted", 32'(sof_busy), 1);
        chk("restart_first_bit", 32'(sof), 1);
        watch(32, -1, d);
        chk("done_after_restart", 32'(d), 32'(32 + G));
        tick();

        // Abort at cycle 10, then reset at cycle 10: no done in either case.
        for (int mode = 0; mode < 2; mode++) begin
            tick();
            start_seq(4'd1);
            repeat (10) tick();
            if (mode == 0) abort = 1'b1;
            else           rst_n = 1'b0;
            tick();
            abort = 1'b0;
            rst_n = 1'b1;
            chk("cancel_sof", 32'(sof), 0);
            chk("cancel_busy", 32'(sof_busy), 0);
            ndone = 0;
            repeat (80) begin
                if (sof_done) ndone++;
                tick();
            end
            chk("cancel_no_done", 32'(ndone), 0);
        end
        start_seq(4'd0);
        watch(32, -1, d);
        chk("done_after_cancel", 32'(d), 32'(32 + G));
        tick();

        // Random traffic against the model.
        repeat (5000) begin
            control_sof = ($urandom_range(0, 7) == 0);
            rep         = 4'($urandom_range(0, 3));
            abort       = ($urandom_range(0, 199) == 0);
            rst_n       = ($urandom_range(0, 299) != 0);
            tick();
        end
        control_sof = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        repeat (300) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
